instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 157 +++++++++++++++
 tb/tb_instr_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Two-stage pipelined encoder from RV32 fields to instruction words,
//            with an immediate-range error flag and a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_JALR    = 7'b1100111;
    localparam logic [6:0] c_LOAD    = 7'b0000011;
    localparam logic [6:0] c_LOAD_FP = 7'b0000111;
    localparam logic [6:0] c_STORE   = 7'b0100011;
    localparam logic [6:0] c_STORE_F = 7'b0100111;
    localparam logic [6:0] c_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_LUI     = 7'b0110111;
    localparam logic [6:0] c_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_JAL     = 7'b1101111;

    logic             s1_valid_q;
    logic [6:0]       op_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    logic [31:0]      imm_q;

    logic             s2_valid_q;
    logic [31:0]      instr_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic [31:0]      instr_d;
    logic             err_d;

    assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !rst && (!s1_valid_q || s2_load);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid_q && out_ready;

    assign out_valid = s2_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    // Word is always built from the truncated fields; err only flags lost bits.
    always_comb begin
        instr_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, op_q};
        err_d   = 1'b0;
        case (op_q)
            c_OP_IMM, c_JALR, c_LOAD, c_LOAD_FP: begin
                if (op_q == c_OP_IMM && (funct3_q == 3'b001 || funct3_q == 3'b101)) begin
                    instr_d = {funct7_q, imm_q[4:0], rs1_q, funct3_q, rd_q, op_q};
                    err_d   = (imm_q[31:5] != 27'd0);
                end else begin
                    instr_d = {imm_q[11:0], rs1_q, funct3_q, rd_q, op_q};
                    err_d   = (imm_q[31:11] != {21{imm_q[11]}});
                end
            end
            c_STORE, c_STORE_F: begin
                instr_d = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], op_q};
                err_d   = (imm_q[31:11] != {21{imm_q[11]}});
            end
            c_BRANCH: begin
                instr_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                           imm_q[4:1], imm_q[11], op_q};
                err_d   = imm_q[0] || (imm_q[31:12] != {20{imm_q[12]}});
            end
            c_LUI, c_AUIPC: begin
                instr_d = {imm_q[31:12], rd_q, op_q};
                err_d   = (imm_q[11:0] != 12'd0);
            end
            c_JAL: begin
                instr_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                err_d   = imm_q[0] || (imm_q[31:20] != {12{imm_q[20]}});
            end
            default: begin
                instr_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, op_q};
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            imm_q      <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            op_q       <= op;
            rd_q       <= rd;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            funct3_q   <= funct3;
            funct7_q   <= funct7;
            imm_q      <= imm;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            instr_q    <= instr_d;
            err_q      <= err_d;
        end else if (out_fire) begin
            s2_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (out_fire && err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Randomized and directed bench for instr_encoder against a
//            field-rule reference model and an immediate-decode check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int CNT_W = 3;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fld_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          acc_cycle;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    instr_encoder #(.CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    exp_t        exp_q[$];
    int          model_cnt = 0;
    int          last_lat;
    int          last_pop_cycle;
    logic [31:0] last_instr;
    logic        last_err;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic is_itype(input logic [6:0] o);
        return o == 7'b0010011 || o == 7'b1100111 || o == 7'b0000011 || o == 7'b0000111;
    endfunction

    // Reference: field placement from the encoding table, err from numeric ranges.
    function automatic exp_t ref_enc(input fld_t f);
        exp_t e;
        int   s;
        s = $signed(f.imm);
        e.imm = f.imm; e.op = f.op; e.f3 = f.f3; e.acc_cycle = 0;
        e.instr = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
        e.err   = 1'b0;
        if (f.op == 7'b0010011 && (f.f3 == 3'd1 || f.f3 == 3'd5)) begin
            e.instr = {f.f7, f.imm[4:0], f.rs1, f.f3, f.rd, f.op};
            e.err   = f.imm > 32'd31;
        end else if (is_itype(f.op)) begin
            e.instr = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
            e.err   = !(s >= -2048 && s <= 2047);
        end else if (f.op == 7'b0100011 || f.op == 7'b0100111) begin
            e.instr = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
            e.err   = !(s >= -2048 && s <= 2047);
        end else if (f.op == 7'b1100011) begin
            e.instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
            e.err   = (s % 2 != 0) || s < -4096 || s > 4095;
        end else if (f.op == 7'b0110111 || f.op == 7'b0010111) begin
            e.instr = {f.imm[31:12], f.rd, f.op};
            e.err   = (f.imm % 4096) != 0;
        end else if (f.op == 7'b1101111) begin
            e.instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
            e.err   = (s % 2 != 0) || s < -(1 << 20) || s > (1 << 20) - 1;
        end
        return e;
    endfunction

    // Core-style immediate generator applied to an emitted word.
    function automatic logic [31:0] dec_imm(input logic [31:0] w, input logic [2:0] f3);
        logic [6:0] o;
        o = w[6:0];
        if (o == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) return {27'd0, w[24:20]};
        if (is_itype(o)) return {{20{w[31]}}, w[31:20]};
        if (o == 7'b0100011 || o == 7'b0100111) return {{20{w[31]}}, w[31:25], w[11:7]};
        if (o == 7'b1100011) return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (o == 7'b0110111 || o == 7'b0010111) return {w[31:12], 12'd0};
        if (o == 7'b1101111) return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'd0;
    endfunction

    task automatic step(input logic iv, input fld_t f, input logic ordy, input logic r,
                        output logic acc, output logic pop);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; out_ready = ordy;
        op = f.op; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        funct3 = f.f3; funct7 = f.f7; imm = f.imm;
        #1;
        acc = 1'b0; pop = 1'b0;
        if (r) begin
            chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
            exp_q.delete();
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            chk("err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, model_cnt);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_err", {31'd0, err}, {31'd0, prev_err});
            end
            acc = iv && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr, e.instr);
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    last_lat = cycle - e.acc_cycle;
                    chk("latency_min", {31'd0, last_lat >= 2}, 32'd1);
                    if (!e.err && (is_itype(e.op) || e.op == 7'b0100011 || e.op == 7'b0100111 ||
                                   e.op == 7'b1100011 || e.op == 7'b0110111 ||
                                   e.op == 7'b0010111 || e.op == 7'b1101111))
                        chk("decode_imm", dec_imm(instr, e.f3), e.imm);
                    if (e.err && model_cnt < (1 << CNT_W) - 1) model_cnt++;
                end
                last_instr = instr; last_err = err; last_pop_cycle = cycle;
            end
            if (acc) begin
                e = ref_enc(f);
                e.acc_cycle = cycle;
                exp_q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = instr;
            prev_err   = err;
        end
        @(posedge clk);
        cycle++;
    endtask

    fld_t idle_f = '{7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0};

    // Offer one field set until accepted, then wait until it is emitted.
    task automatic send_one(input fld_t f);
        logic a, p;
        int   n;
        a = 1'b0; n = 0;
        while (!a && n < 20) begin step(1'b1, f, 1'b1, 1'b0, a, p); n++; end
        if (!a) chk("accept_timeout", 32'd0, 32'd1);
        p = 1'b0; n = 0;
        while (!p && n < 20) begin step(1'b0, idle_f, 1'b1, 1'b0, a, p); n++; end
        if (!p) chk("output_timeout", 32'd0, 32'd1);
    endtask

    function automatic fld_t rand_fld();
        logic [6:0] ops[12] = '{7'b0010011, 7'b1100111, 7'b0000011, 7'b0000111,
                                7'b0100011, 7'b0100111, 7'b1100011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b0110011, 7'b0010011};
        fld_t f;
        f.op  = ($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 12];
        f.rd  = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom); f.f7  = 7'($urandom);
        case ($urandom % 5)
            0: f.imm = $urandom;
            1: f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: f.imm = $urandom & 32'hFFFF_F000;
            3: f.imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
            default: f.imm = 32'($urandom_range(0, 40));
        endcase
        return f;
    endfunction

    initial begin
        logic a, p;
        int   acc_n, pop_n, first_pop, n;
        fld_t f;
        fld_t seq[3];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

        step(1'b1, idle_f, 1'b1, 1'b1, a, p);
        step(1'b1, idle_f, 1'b1, 1'b1, a, p);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); cycle++;

        // Directed encodings
        send_one('{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF});
        chk("addi_instr", last_instr, 32'hFFF0_0093);
        chk("addi_err", {31'd0, last_err}, 32'd0);
        chk("addi_latency", last_lat, 32'd2);
        send_one('{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8});
        chk("beq_instr", last_instr, 32'h0000_0463);
        send_one('{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000});
        chk("lui_instr", last_instr, 32'h1234_52B7);
        send_one('{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048});
        chk("jal_instr", last_instr, 32'h0010_00EF);

        send_one('{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3});
        chk("br_err", {31'd0, last_err}, 32'd1);
        step(1'b0, idle_f, 1'b1, 1'b0, a, p);
        chk("br_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd1);
        send_one('{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1});
        chk("lui_err", {31'd0, last_err}, 32'd1);
        step(1'b0, idle_f, 1'b1, 1'b0, a, p);
        chk("lui_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd2);

        // Backpressure: three offered while stalled, two held
        for (int i = 0; i < 3; i++) seq[i] = rand_fld();
        n = 0; acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[n], 1'b0, 1'b0, a, p);
            if (a) begin acc_n++; n++; end
        end
        chk("bp_accepted", acc_n, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        pop_n = 0; first_pop = 0;
        for (int i = 0; i < 12 && pop_n < 3; i++) begin
            step(n < 3, seq[(n < 3) ? n : 2], 1'b1, 1'b0, a, p);
            if (a) n++;
            if (p) begin if (pop_n == 0) first_pop = last_pop_cycle; pop_n++; end
        end
        chk("bp_popped", pop_n, 32'd3);
        chk("bp_consecutive", last_pop_cycle - first_pop, 32'd2);

        // Streaming: ten back-to-back words, ten consecutive outputs
        n = 0; pop_n = 0; first_pop = 0;
        for (int i = 0; i < 30 && pop_n < 10; i++) begin
            f = rand_fld();
            step(n < 10, f, 1'b1, 1'b0, a, p);
            if (a) n++;
            if (p) begin if (pop_n == 0) first_pop = last_pop_cycle; pop_n++; end
        end
        chk("stream_count", pop_n, 32'd10);
        chk("stream_consecutive", last_pop_cycle - first_pop, 32'd9);
        chk("stream_latency", last_lat, 32'd2);

        // Reset with two words buffered
        for (int i = 0; i < 3; i++) step(1'b1, rand_fld(), 1'b0, 1'b0, a, p);
        step(1'b1, rand_fld(), 1'b1, 1'b1, a, p);
        step(1'b0, idle_f, 1'b1, 1'b0, a, p);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, idle_f, 1'b1, 1'b0, a, p);

        // Random traffic with random backpressure
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, rand_fld(), ($urandom % 10) < 7, 1'b0, a, p);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b0, idle_f, 1'b1, 1'b0, a, p);
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        step(1'b0, idle_f, 1'b1, 1'b0, a, p);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
